dtw_core_ctrl: RTL and testbench

Sequencer for the DTW systolic datapath: it collects one query squiggle of SQG_SIZE samples from an upstream valid/ready stream and streams ref_len reference words from a synchronous-read memory into the datapath. It drives the datapath's synchronous reset and run enable, then captures its minimum cost and position into a held result register with a valid/ready handshake. It sits between the host/stream front end and the DTW core, one instance per core.

---
 rtl/dtw_core_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_dtw_core_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtw_core_ctrl.sv
`timescale 1ns/1ps
// dtw_core_ctrl: loads one query squiggle, streams reference words into the DTW datapath
// and holds its minimum cost/position result. Define DTW_CTRL_HIT_EN to register result_hit.
module dtw_core_ctrl #(
    parameter int width    = 16,
    parameter int SQG_SIZE = 10,
    parameter int ADDR_W   = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       ref_len,
    input  logic [width-1:0]  threshold,
    output logic              busy,
    input  logic              sqg_valid,
    output logic              sqg_ready,
    input  logic [width-1:0]  sqg_data,
    output logic              ref_rd_en,
    output logic [ADDR_W-1:0] ref_addr,
    input  logic [width-1:0]  ref_rdata,
    output logic              dp_rst,
    output logic              dp_running,
    output logic [width-1:0]  dp_squiggle,
    output logic [width-1:0]  dp_rword,
    output logic [31:0]       dp_ref_len,
    input  logic [width-1:0]  dp_minval,
    input  logic [31:0]       dp_position,
    input  logic              dp_done,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [width-1:0]  result_minval,
    output logic [31:0]       result_position,
    output logic              result_hit
);

    localparam int IDX_W = (SQG_SIZE > 1) ? $clog2(SQG_SIZE) : 1;

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_FLUSH, ST_DONE} state_e;
    typedef enum logic [1:0] {RW_ZERO, RW_MEM, RW_ONES} rword_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       run_cnt_q, run_cnt_d;
    logic [31:0]       len_q, len_d;
    logic [width-1:0]  sqg_buf_q [SQG_SIZE];
    logic              sqg_acc;
    logic              hit_cmp;
    logic [IDX_W-1:0]  sq_idx;

    logic              ref_rd_en_q, ref_rd_en_d;
    logic [ADDR_W-1:0] ref_addr_q, ref_addr_d;
    logic              dp_running_q, dp_running_d;
    logic [width-1:0]  dp_squiggle_q, dp_squiggle_d;
    rword_e            rword_mode_q, rword_mode_d;
    logic [31:0]       dp_ref_len_q, dp_ref_len_d;
    logic              result_valid_q, result_valid_d;
    logic [width-1:0]  result_minval_q, result_minval_d;
    logic [31:0]       result_position_q, result_position_d;
    logic              result_hit_q, result_hit_d;

    assign sqg_ready = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_IDLE);
    assign dp_rst    = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign sqg_acc   = sqg_valid && sqg_ready;

`ifdef DTW_CTRL_HIT_EN
    assign hit_cmp = (dp_minval < threshold);
`else
    logic unused_threshold;
    assign unused_threshold = ^threshold;
    assign hit_cmp          = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            idx_q             <= '0;
            run_cnt_q         <= '0;
            len_q             <= '0;
            ref_rd_en_q       <= 1'b0;
            ref_addr_q        <= '0;
            dp_running_q      <= 1'b0;
            dp_squiggle_q     <= '0;
            rword_mode_q      <= RW_ZERO;
            dp_ref_len_q      <= '0;
            result_valid_q    <= 1'b0;
            result_minval_q   <= '0;
            result_position_q <= '0;
            result_hit_q      <= 1'b0;
        end else begin
            state_q           <= state_d;
            idx_q             <= idx_d;
            run_cnt_q         <= run_cnt_d;
            len_q             <= len_d;
            ref_rd_en_q       <= ref_rd_en_d;
            ref_addr_q        <= ref_addr_d;
            dp_running_q      <= dp_running_d;
            dp_squiggle_q     <= dp_squiggle_d;
            rword_mode_q      <= rword_mode_d;
            dp_ref_len_q      <= dp_ref_len_d;
            result_valid_q    <= result_valid_d;
            result_minval_q   <= result_minval_d;
            result_position_q <= result_position_d;
            result_hit_q      <= result_hit_d;
        end
    end

    // NOTE: the sample buffer has no reset; the load index is what makes stale samples irrelevant.
    always_ff @(posedge clk) begin
        if (sqg_acc) begin
            sqg_buf_q[idx_q] <= sqg_data;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        run_cnt_d = run_cnt_q;
        len_d     = len_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = ref_len;
                    idx_d   = '0;
                    state_d = (ref_len == 32'd0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (sqg_acc) begin
                    if (idx_q == IDX_W'(SQG_SIZE - 1)) begin
                        state_d   = ST_RUN;
                        run_cnt_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                run_cnt_d = run_cnt_q + 32'd1;
                if (dp_done) state_d = ST_FLUSH;
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  if (result_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Registered outputs are computed from the next state so they line up with the state they describe.
    always_comb begin
        ref_rd_en_d       = 1'b0;
        ref_addr_d        = '0;
        dp_running_d      = 1'b0;
        dp_squiggle_d     = '0;
        rword_mode_d      = RW_ZERO;
        dp_ref_len_d      = dp_ref_len_q;
        result_valid_d    = (state_d == ST_DONE);
        result_minval_d   = result_minval_q;
        result_position_d = result_position_q;
        result_hit_d      = result_hit_q;
        sq_idx            = IDX_W'(run_cnt_d - 32'd1);

        if (state_q == ST_IDLE && start) dp_ref_len_d = ref_len + 32'(SQG_SIZE);

        if (state_d == ST_RUN || state_d == ST_FLUSH) begin
            dp_running_d = 1'b1;
            rword_mode_d = RW_ONES;
        end
        if (state_d == ST_RUN) begin
            ref_rd_en_d = (run_cnt_d < len_q);
            ref_addr_d  = run_cnt_d[ADDR_W-1:0];
            if (run_cnt_d != 32'd0 && run_cnt_d <= len_q) rword_mode_d = RW_MEM;
            if (run_cnt_d != 32'd0 && run_cnt_d <= 32'(SQG_SIZE)) dp_squiggle_d = sqg_buf_q[sq_idx];
        end

        if (state_d == ST_DONE && state_q != ST_DONE) begin
            if (state_q == ST_IDLE) begin
                result_minval_d   = '1;
                result_position_d = '0;
                result_hit_d      = 1'b0;
            end else begin
                result_minval_d   = dp_minval;
                result_position_d = dp_position;
                result_hit_d      = hit_cmp;
            end
        end
    end

    // ref_rdata is already the memory's output register; re-flopping it would skew words by a cycle.
    always_comb begin
        unique case (rword_mode_q)
            RW_MEM:  dp_rword = ref_rdata;
            RW_ONES: dp_rword = '1;
            default: dp_rword = '0;
        endcase
    end

    assign ref_rd_en       = ref_rd_en_q;
    assign ref_addr        = ref_addr_q;
    assign dp_running      = dp_running_q;
    assign dp_squiggle     = dp_squiggle_q;
    assign dp_ref_len      = dp_ref_len_q;
    assign result_valid    = result_valid_q;
    assign result_minval   = result_minval_q;
    assign result_position = result_position_q;
    assign result_hit      = result_hit_q;

endmodule

// File: tb/tb_dtw_core_ctrl.sv
`timescale 1ns/1ps
// Directed bench for dtw_core_ctrl with SQG_SIZE=4, a synchronous-read reference memory
// and a behavioural DTW datapath that records what it was fed and reports the best match.
module tb_dtw_core_ctrl;

    localparam int W  = 16;
    localparam int S  = 4;
    localparam int AW = 20;
`ifdef DTW_CTRL_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   ref_len = '0;
    logic [W-1:0]  threshold = '0;
    logic          busy;
    logic          sqg_valid = 1'b0;
    logic          sqg_ready;
    logic [W-1:0]  sqg_data = '0;
    logic          ref_rd_en;
    logic [AW-1:0] ref_addr;
    logic [W-1:0]  ref_rdata = '0;
    logic          dp_rst;
    logic          dp_running;
    logic [W-1:0]  dp_squiggle;
    logic [W-1:0]  dp_rword;
    logic [31:0]   dp_ref_len;
    logic [W-1:0]  dp_minval = '0;
    logic [31:0]   dp_position = '0;
    logic          dp_done = 1'b0;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic [W-1:0]  result_minval;
    logic [31:0]   result_position;
    logic          result_hit;

    int n_chk = 0;
    int n_err = 0;

    dtw_core_ctrl #(.width(W), .SQG_SIZE(S), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ref_len(ref_len), .threshold(threshold),
        .busy(busy), .sqg_valid(sqg_valid), .sqg_ready(sqg_ready), .sqg_data(sqg_data),
        .ref_rd_en(ref_rd_en), .ref_addr(ref_addr), .ref_rdata(ref_rdata),
        .dp_rst(dp_rst), .dp_running(dp_running), .dp_squiggle(dp_squiggle),
        .dp_rword(dp_rword), .dp_ref_len(dp_ref_len), .dp_minval(dp_minval),
        .dp_position(dp_position), .dp_done(dp_done), .result_valid(result_valid),
        .result_ready(result_ready), .result_minval(result_minval),
        .result_position(result_position), .result_hit(result_hit)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem [16];
    logic [W-1:0] qv  [S];
    initial begin
        mem = '{16'd20, 16'd40, 16'd60, 16'd80, 16'd100, 16'd120, 16'd3, 16'd5,
                16'd7, 16'd9, 16'd200, 16'd220, 16'd0, 16'd0, 16'd0, 16'd0};
        qv  = '{16'd3, 16'd5, 16'd7, 16'd9};
    end

    always @(posedge clk) begin
        if (ref_rd_en) ref_rdata <= (ref_addr < 20'd16) ? mem[ref_addr[3:0]] : 16'hDEAD;
    end

    // Address monitor: reads must walk 0,1,2,... once each
    int addr_n, addr_bad;
    always @(posedge clk) begin
        if (dp_rst) begin
            addr_n   <= 0;
            addr_bad <= 0;
        end else if (ref_rd_en) begin
            if (ref_addr != AW'(addr_n)) addr_bad <= addr_bad + 1;
            addr_n <= addr_n + 1;
        end
    end

    // Behavioural datapath: cycle 0 is prime, then squiggle/rword samples are recorded
    int           k, pad_bad, dl;
    logic [W-1:0] qcap [S];
    logic [W-1:0] rcap [32];

    function automatic int absd(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a > b) ? int'(a - b) : int'(b - a);
    endfunction

    function automatic void dtw(input int len, output int best, output int pos);
        int d [S][32];
        best = 32'h7fffffff;
        pos  = 0;
        for (int i = 0; i < S; i++) begin
            for (int j = 0; j < len; j++) begin
                int m;
                if (i == 0) m = 0;
                else if (j == 0) m = d[i-1][0];
                else begin
                    m = d[i-1][j-1];
                    if (d[i-1][j] < m) m = d[i-1][j];
                    if (d[i][j-1] < m) m = d[i][j-1];
                end
                d[i][j] = absd(qcap[i], rcap[j]) + m;
            end
        end
        for (int j = 0; j < len; j++) begin
            if (d[S-1][j] < best) begin
                best = d[S-1][j];
                pos  = j;
            end
        end
    endfunction

    always @(posedge clk) begin
        int bst, ps, pb;
        if (dp_rst) begin
            k = 0;
            pad_bad <= 0;
            dp_done <= 1'b0;
            dp_minval <= '0;
            dp_position <= '0;
        end else if (dp_running) begin
            dl = int'(dp_ref_len) - S;
            pb = pad_bad;
            if (k >= 1 && k <= S) qcap[k-1] = dp_squiggle;
            if (k > S && dp_squiggle != '0) pb++;
            if (k >= 1 && k <= dl && k <= 32) rcap[k-1] = dp_rword;
            if (k >= 1 && k > dl && dp_rword != '1) pb++;
            pad_bad <= pb;
            if (k == dl + 2 * S && dl <= 32) begin
                dtw(dl, bst, ps);
                dp_minval   <= W'(bst);
                dp_position <= 32'(ps);
                dp_done     <= 1'b1;
            end
            k = k + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_query(input bit gap, input string tag);
        int n, c, lc;
        bit vr;
        start = 1'b1;
        ref_len = 32'd12;
        tick();
        start = 1'b0;
        check({tag, "_ready_after_start"}, sqg_ready, 1);
        n = 0; c = 0; lc = 0;
        while (n < S && c < 100) begin
            sqg_valid = !(gap && (c % 2 == 0));
            sqg_data  = qv[n];
            if (sqg_ready) lc++;
            vr = sqg_valid && sqg_ready;
            tick();
            if (vr) n++;
            c++;
        end
        sqg_valid = 1'b0;
        check({tag, "_load_cycles"}, lc, gap ? 8 : 4);
        check({tag, "_run_start"}, dp_running, 1);
        check({tag, "_dp_ref_len"}, dp_ref_len, 16);
    endtask

    task automatic finish_run(input logic [W-1:0] thr, input string tag);
        int c, rc;
        rc = 0; c = 0;
        while (!result_valid && c < 200) begin
            if (dp_running) rc++;
            tick();
            c++;
        end
        check({tag, "_valid"}, result_valid, 1);
        check({tag, "_run_cycles"}, rc, 23);
        check({tag, "_minval"}, result_minval, 0);
        check({tag, "_position"}, result_position, 9);
        check({tag, "_hit"}, result_hit, (HIT_EN && thr > 0) ? 1 : 0);
        check({tag, "_addr_cnt"}, addr_n, 12);
        check({tag, "_addr_order"}, addr_bad, 0);
        check({tag, "_padding"}, pad_bad, 0);
    endtask

    initial begin
        int c, seen, bad;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_dp_rst", dp_rst, 1);
        check("rst_sqg_ready", sqg_ready, 0);
        check("rst_valid", result_valid, 0);
        check("rst_ref_addr", ref_addr, 0);
        check("rst_dp_ref_len", dp_ref_len, 0);
        check("rst_dp_rword", dp_rword, 0);
        rst_n = 1'b1;
        tick();

        // Zero-length reference: straight to DONE with the sentinel result
        threshold = 16'hFFFF;
        start = 1'b1;
        ref_len = 32'd0;
        tick();
        start = 1'b0;
        seen = 0; c = 0;
        while (!result_valid && c < 2) begin
            if (sqg_ready || ref_rd_en) seen++;
            tick();
            c++;
        end
        if (sqg_ready || ref_rd_en) seen++;
        check("zl_valid", result_valid, 1);
        check("zl_minval", result_minval, 32'hFFFF);
        check("zl_position", result_position, 0);
        check("zl_hit", result_hit, 0);
        check("zl_no_access", seen, 0);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("zl_idle", busy, 0);

        // Exact-match run, threshold 1
        threshold = 16'd1;
        load_query(1'b0, "run1");
        finish_run(16'd1, "run1");
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("run1_idle", busy, 0);

        // Gapped load, threshold 0, then a long result stall with ignored starts
        threshold = 16'd0;
        load_query(1'b1, "run2");
        finish_run(16'd0, "run2");
        bad = 0;
        ref_len = 32'd0;
        for (int i = 0; i < 20; i++) begin
            start = (i % 5 == 2);
            tick();
            if (!result_valid || !busy || result_minval != '0 || result_position != 32'd9) bad++;
        end
        start = 1'b0;
        check("hold_stable", bad, 0);
        result_ready = 1'b1;
        start = 1'b1;
        tick();
        result_ready = 1'b0;
        start = 1'b0;
        check("hold_release_idle", busy, 0);
        check("hold_release_valid", result_valid, 0);
        tick();
        check("start_with_ready_ignored", busy, 0);
        check("result_held_in_idle", result_position, 9);

        // Reset in the middle of RUN, then a clean run
        threshold = 16'd1;
        load_query(1'b0, "abort");
        repeat (8) tick();
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_dp_rst", dp_rst, 1);
        check("abort_running", dp_running, 0);
        check("abort_rd_en", ref_rd_en, 0);
        check("abort_addr", ref_addr, 0);
        check("abort_rword", dp_rword, 0);
        check("abort_squiggle", dp_squiggle, 0);
        check("abort_ref_len", dp_ref_len, 0);
        check("abort_minval", result_minval, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        load_query(1'b0, "run3");
        finish_run(16'd1, "run3");
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
